srlatch_driver: RTL and testbench

Clocked front end for the LDCPE-based SR latch. Accepts set/clear commands over a valid/ready handshake and drives the latch S (preset) and R (gate, D=0) inputs with pulses of fixed width, never overlapping, separated by a dead time. It then confirms the latch state through a synchronizer on Q and reports completion or timeout. It sits directly upstream of the latch and owns the only drivers of its S and R pins.

---
 rtl/srlatch_pkg.sv | 26 ++
 rtl/srlatch_driver_bit_sync.sv | 24 ++
 rtl/srlatch_driver.sv | 168 ++++++++++++++++
 tb/tb_srlatch_driver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/srlatch_pkg.sv
// Shared types and constants for the SR latch front end.
package srlatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_CHECK = 2'd3
   } state_e;

   localparam logic OP_CLR = 1'b0;
   localparam logic OP_SET = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      return m;
   endfunction

   // Counter width able to hold the largest timed-state load value.
   function automatic int cnt_width(input int pw, input int gw, input int to);
      return $clog2(max3(pw, gw, to) + 1);
   endfunction

endpackage

// File: rtl/srlatch_driver_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, resets to 0.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/srlatch_driver.sv
// Clocked front end for an SR latch: non-overlapping S/R pulses with dead time,
// then confirmation of the latch state through a synchronizer on Q.
module srlatch_driver
   import srlatch_pkg::*;
#(
   parameter int PULSE_W     = 2,
   parameter int GAP_W       = 1,
   parameter int TIMEOUT     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid_i,
   input  logic req_op_i,
   output logic req_ready_o,
   input  logic q_i,
   output logic s_o,
   output logic r_o,
   output logic busy_o,
   output logic done_o,
   output logic err_o,
   output logic q_sync_o
);

   localparam int CW = cnt_width(PULSE_W, GAP_W, TIMEOUT);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_PULSE = CW'(PULSE_W);
   localparam logic [CW-1:0] CNT_GAP   = CW'(GAP_W);
   localparam logic [CW-1:0] CNT_TO    = CW'(TIMEOUT);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            exp_q, exp_d;
   logic            q_sync_s;
   logic            match_s;
   logic            cnt_last_s;

   logic            s_q, s_d;
   logic            r_q, r_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            ready_q, ready_d;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_q_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (q_i),
      .q_o   (q_sync_s)
   );

   assign match_s    = (q_sync_s == exp_q);
   assign cnt_last_s = (cnt_q == CNT_ONE);

   // State, shared down-counter and expected latch value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         exp_q   <= OP_CLR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               exp_d   = req_op_i;
               cnt_d   = CNT_PULSE;
               state_d = ST_PULSE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (cnt_last_s) begin
               cnt_d   = CNT_GAP;
               state_d = ST_GAP;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt_last_s) begin
               cnt_d   = CNT_TO;
               state_d = ST_CHECK;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         ST_CHECK: begin
            // First match wins; otherwise give up after the last allowed cycle.
            if (match_s || cnt_last_s) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the next cycle, decoded from the next state so S/R stay registered.
   always_comb begin
      s_d     = 1'b0;
      r_d     = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
      if (state_d == ST_PULSE) begin
         s_d = (exp_d == OP_SET);
         r_d = (exp_d == OP_CLR);
      end else begin
         s_d = 1'b0;
         r_d = 1'b0;
      end
      if (state_q == ST_CHECK) begin
         done_d = match_s;
         err_d  = !match_s && cnt_last_s;
      end else begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
   end

   // Output registers; reset clears the latch drives without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         s_q     <= s_d;
         r_q     <= r_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign s_o         = s_q;
   assign r_o         = r_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign busy_o      = busy_q;
   assign req_ready_o = ready_q;
   assign q_sync_o    = q_sync_s;

endmodule

// File: tb/tb_srlatch_driver.sv
// Randomized bench for srlatch_driver with a timeline-based reference model and a behavioural latch.
module tb_srlatch_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic valid [2];
   logic op    [2];
   logic q_lat [2];
   logic ready_w [2];
   logic s_w     [2];
   logic r_w     [2];
   logic busy_w  [2];
   logic done_w  [2];
   logic err_w   [2];
   logic qs_w    [2];

   int checks   = 0;
   int failures = 0;

   int cfg_pw [2] = '{2, 4};
   int cfg_gw [2] = '{1, 2};
   int cfg_to [2] = '{8, 8};
   int cfg_sy [2] = '{2, 3};

   srlatch_driver #(.PULSE_W(2), .GAP_W(1), .TIMEOUT(8), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid_i(valid[0]), .req_op_i(op[0]),
      .req_ready_o(ready_w[0]), .q_i(q_lat[0]), .s_o(s_w[0]), .r_o(r_w[0]),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .err_o(err_w[0]), .q_sync_o(qs_w[0]));

   srlatch_driver #(.PULSE_W(4), .GAP_W(2), .TIMEOUT(8), .SYNC_STAGES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid_i(valid[1]), .req_op_i(op[1]),
      .req_ready_o(ready_w[1]), .q_i(q_lat[1]), .s_o(s_w[1]), .r_o(r_w[1]),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .err_o(err_w[1]), .q_sync_o(qs_w[1]));

   task automatic chk(input string nm, input int d, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s dut%0d t=%0t got=%b want=%b", nm, d, $time, got, want);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
      end
   endtask

   // Behavioural latch: follows S/R after a programmable delay, can be stuck or disturbed.
   int  stuck [2];
   int  dly   [2];
   int  lcnt  [2];
   bit  lhave [2];
   bit  ltgt  [2];
   bit  glitch_en;
   always @(posedge clk) begin
      #2;
      for (int d = 0; d < 2; d++) begin
         if (s_w[d] || r_w[d]) begin
            ltgt[d]  = s_w[d];
            lcnt[d]  = dly[d];
            lhave[d] = 1'b1;
         end
         if (lhave[d]) begin
            if (lcnt[d] == 0) begin
               q_lat[d] = ltgt[d];
               lhave[d] = 1'b0;
            end else begin
               lcnt[d]--;
            end
         end
         if (glitch_en && !busy_w[d] && $urandom_range(0, 7) == 0) q_lat[d] = ~q_lat[d];
         if (stuck[d] == 1) q_lat[d] = 1'b0;
         else if (stuck[d] == 2) q_lat[d] = 1'b1;
      end
   end

   bit rst_e = 1'b0;
   int ecnt  = 0;
   always @(posedge clk) begin
      rst_e = rst_n;
      ecnt++;
   end

   // Reference model: each command is a timeline measured in edges from its accept edge.
   bit m_act [2];
   int m_t   [2];
   bit m_exp [2];
   bit m_qs  [2];
   bit hist  [2][8];
   bit v_prev [2];
   bit o_prev [2];
   bit e_done, e_err, qs_new;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         e_done = 1'b0;
         e_err  = 1'b0;
         if (!rst_n) begin
            m_act[d] = 1'b0;
            m_qs[d]  = 1'b0;
            for (int k = 0; k < 8; k++) hist[d][k] = 1'b0;
            v_prev[d] = 1'b0;
         end else begin
            if (rst_e) begin
               qs_new = hist[d][cfg_sy[d]-1];
               if (!m_act[d]) begin
                  if (v_prev[d]) begin
                     m_act[d] = 1'b1;
                     m_t[d]   = 0;
                     m_exp[d] = o_prev[d];
                  end
               end else begin
                  m_t[d]++;
                  if (m_t[d] > cfg_pw[d] + cfg_gw[d]) begin
                     if (m_qs[d] == m_exp[d]) begin
                        e_done   = 1'b1;
                        m_act[d] = 1'b0;
                     end else if (m_t[d] == cfg_pw[d] + cfg_gw[d] + cfg_to[d]) begin
                        e_err    = 1'b1;
                        m_act[d] = 1'b0;
                     end
                  end
               end
               m_qs[d] = qs_new;
            end
            for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
            hist[d][0] = q_lat[d];
            v_prev[d]  = valid[d];
            o_prev[d]  = op[d];
         end
         chk("s",      d, s_w[d],     m_act[d] && m_t[d] < cfg_pw[d] && m_exp[d]);
         chk("r",      d, r_w[d],     m_act[d] && m_t[d] < cfg_pw[d] && !m_exp[d]);
         chk("busy",   d, busy_w[d],  m_act[d]);
         chk("ready",  d, ready_w[d], !m_act[d]);
         chk("done",   d, done_w[d],  e_done);
         chk("err",    d, err_w[d],   e_err);
         chk("q_sync", d, qs_w[d],    m_qs[d]);
      end
   end

   task automatic issue(input int d, input logic o, input bit keep, output int e0);
      bit ok;
      ok = 1'b0;
      e0 = -1;
      for (int i = 0; i < 60 && busy_w[d]; i++) begin
         @(posedge clk); #2;
      end
      chk("idle_wait", d, busy_w[d], 1'b0);
      valid[d] = 1'b1;
      op[d]    = o;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk); #2;
         if (busy_w[d]) begin
            ok = 1'b1;
            e0 = ecnt;
         end
      end
      if (!keep) valid[d] = 1'b0;
      chk("accept", d, ok, 1'b1);
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   int e0, e1;
   initial begin
      rst_n = 1'b0;
      glitch_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         valid[d] = 1'b1; op[d] = 1'b1; q_lat[d] = 1'b0;
         stuck[d] = 0; dly[d] = 0; lcnt[d] = 0; lhave[d] = 1'b0; ltgt[d] = 1'b0;
      end
      repeat (3) step();
      chk("rst_ready", 0, ready_w[0], 1'b1);
      chk("rst_busy",  0, busy_w[0],  1'b0);
      chk("rst_s",     1, s_w[1],     1'b0);
      valid[0] = 1'b0; valid[1] = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (2) step();

      // Single set on the default configuration.
      issue(0, 1'b1, 1'b0, e0);
      chk("set_s_e0", 0, s_w[0], 1'b1);
      chk("set_r_e0", 0, r_w[0], 1'b0);
      step(); chk("set_s_e1", 0, s_w[0], 1'b1);
      step(); chk("set_s_e2", 0, s_w[0], 1'b0); chk("set_qs_e2", 0, qs_w[0], 1'b1);
      step(); chk("set_done_e3", 0, done_w[0], 1'b0);
      step(); chk("set_done_e4", 0, done_w[0], 1'b1); chk("set_ready_e4", 0, ready_w[0], 1'b1);

      // Back-to-back set then clear with VALID held high.
      issue(0, 1'b1, 1'b1, e0);
      op[0] = 1'b0;
      issue(0, 1'b0, 1'b0, e1);
      chk_int("b2b_period", e1 - e0, 5);
      chk("b2b_r_e5", 0, r_w[0], 1'b1);
      step(); chk("b2b_r_e6", 0, r_w[0], 1'b1);
      step(); chk("b2b_r_e7", 0, r_w[0], 1'b0);
      step(); chk("b2b_done_e8", 0, done_w[0], 1'b0);
      step(); chk("b2b_done_e9", 0, done_w[0], 1'b1);

      // Latch stuck at 0: set must time out.
      stuck[0] = 1;
      step();
      issue(0, 1'b1, 1'b0, e0);
      repeat (10) step();
      chk("stuck_err_e10", 0, err_w[0], 1'b0);
      step();
      chk("stuck_err_e11",   0, err_w[0],   1'b1);
      chk("stuck_done_e11",  0, done_w[0],  1'b0);
      chk("stuck_ready_e11", 0, ready_w[0], 1'b1);
      stuck[0] = 0;
      step();

      // Reset in the middle of a pulse.
      issue(0, 1'b1, 1'b0, e0);
      chk("abort_s_before", 0, s_w[0], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_s_async",    0, s_w[0],    1'b0);
      chk("abort_busy_async", 0, busy_w[0], 1'b0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (15) step();
      chk("abort_idle", 0, ready_w[0], 1'b1);

      // Wider pulse/gap and deeper synchronizer: set, then clear.
      issue(1, 1'b1, 1'b0, e0);
      issue(1, 1'b0, 1'b0, e0);
      chk("b_r_e0", 1, r_w[1], 1'b1);
      for (int k = 1; k < 4; k++) begin
         step(); chk("b_r_hold", 1, r_w[1], 1'b1);
      end
      step(); chk("b_r_e4", 1, r_w[1], 1'b0);
      step(); chk("b_done_e5", 1, done_w[1], 1'b0);
      step(); chk("b_done_e6", 1, done_w[1], 1'b0);
      step(); chk("b_done_e7", 1, done_w[1], 1'b1);

      // Randomized commands with latch delays, stuck faults and idle disturbances.
      glitch_en = 1'b1;
      repeat (80) begin
         int d;
         d = $urandom_range(0, 1);
         stuck[d] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
         dly[d]   = $urandom_range(0, 12);
         issue(d, 1'(($urandom_range(0, 1))), 1'b0, e0);
         repeat ($urandom_range(0, 3)) step();
      end
      glitch_en = 1'b0;
      repeat (30) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t got=running want=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
